multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle MIPS main control FSM that drives every datapath mux select and enable: RegDst, MemtoReg, ALUSrcA/B, PCSource, IorD.
- Also drives ALUOp and the register, memory, IR and PC write strobes.
- Generalised over opcode width and adds an optional memory-ready wait handshake.
- Sits between the instruction register opcode field and the datapath; one instance per core.

Parameters:
- OP_WIDTH, 6, width of op input (opcode field Instruction[31:26]).
- MEM_WAIT_EN, 1, 1 = stall in memory states until mem_ready; 0 = mem_ready ignored, treated as 1.
- STATE_WIDTH, 4, width of state_o encoding.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  OP_WIDTH  opcode from instruction register.
- mem_ready  in  1  memory completes the access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write-register select: 0 = rt[20:16], 1 = rd[15:11].
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- state_o  out  STATE_WIDTH  current state, for debug.

Behaviour:
- State register is the only sequential element. Outputs decode combinationally from state (and mem_ready where noted). Unlisted outputs are 0.
- Reset (asynchronous, active-high): state goes to FETCH immediately. While reset is high, all outputs are forced to 0, including state_o = 0.
- Reset mid-instruction aborts the instruction. No write strobe fires after reset is asserted.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_DONE=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by op: LW/SW → MEM_ADDR; RTYPE → EXECUTE; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EXEC.
  - Any other op: illegal_op=1, next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ for LW, MEM_WRITE for SW. op is held stable by IR during the instruction.
- MEM_READ: mem_read=1, i_or_d=1. Next state MEM_WB if mem_ready, else hold.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, instr_done=mem_ready. Next state FETCH if mem_ready, else hold.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_DONE.
- R_DONE: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- During a wait, mem_read/mem_write and address selects stay asserted and stable. Write/IR strobes stay low until the ready cycle.
- Latency with no waits: LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Unreachable encodings 12–15 go to FETCH with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010, OP_ADDI=001000.
  - state encodings.
  - ALUOp, ALUSrcB and PCSource select encodings.
- No sub-module; a single FSM is the natural shape.

Test Plan:
- Reset asserted mid-MEM_ADDR, op=LW → state_o=0 and all outputs 0 asynchronously. After release, FETCH with mem_read=1.
- LW, mem_ready=1 always → states 0,1,2,3,4. reg_write=1 and mem_to_reg=1 only in cycle 5, with instr_done=1.
- SW, mem_ready low 2 cycles in FETCH and 1 cycle in MEM_WRITE → 7 cycles total. ir_write pulses once. mem_write held 2 cycles; instr_done only on the ready cycle.
- R-type then BEQ back-to-back → R_DONE has reg_dst=1, reg_write=1. BRANCH has alu_op=01, pc_write_cond=1, pc_source=01. Sequence 0,1,6,7,0,1,8,0.
- op=111111 in DECODE → illegal_op=1 for one cycle, next state FETCH, no write strobes asserted.
- MEM_WAIT_EN=0 with mem_ready held 0; J then ADDI → J completes in 3 cycles with pc_source=10, ADDI in 4 cycles with alu_src_b=10 then reg_write=1, reg_dst=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM:
// opcodes, state numbers and datapath select values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_DONE    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: one state register, all datapath
// selects and strobes decoded combinationally from state and mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] state_o
);

    logic [3:0] state_q, state_d;
    logic       ready;
    logic       is_rtype, is_lw, is_sw, is_beq, is_j, is_addi;

    assign ready    = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign is_rtype = (op == OP_WIDTH'(OP_RTYPE));
    assign is_lw    = (op == OP_WIDTH'(OP_LW));
    assign is_sw    = (op == OP_WIDTH'(OP_SW));
    assign is_beq   = (op == OP_WIDTH'(OP_BEQ));
    assign is_j     = (op == OP_WIDTH'(OP_J));
    assign is_addi  = (op == OP_WIDTH'(OP_ADDI));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset gates every output so no strobe can fire once reset is seen.
    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = ready;
                    pc_write  = ready;
                    state_d   = ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    if (is_lw || is_sw) state_d = S_MEM_ADDR;
                    else if (is_rtype)  state_d = S_EXECUTE;
                    else if (is_beq)    state_d = S_BRANCH;
                    else if (is_j)      state_d = S_JUMP;
                    else if (is_addi)   state_d = S_ADDI_EXEC;
                    else                illegal_op = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (is_lw)      state_d = S_MEM_READ;
                    else if (is_sw) state_d = S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = ready ? S_MEM_WB : S_MEM_READ;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = ready;
                    state_d    = ready ? S_FETCH : S_MEM_WRITE;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                    state_d   = S_R_DONE;
                end
                S_R_DONE: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state_o = reset ? '0 : STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one instance with the memory wait
// handshake, one with it disabled; expectations flow through a scoreboard.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic done, ill;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op0 = '0, op1 = '0;
    logic rdy0 = 1'b0, rdy1 = 1'b0;

    logic pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rdst0, rw0, asa0, done0, ill0;
    logic [1:0] asb0, aop0, pcs0;
    logic [3:0] st0;
    logic pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rdst1, rw1, asa1, done1, ill1;
    logic [1:0] asb1, aop1, pcs1;
    logic [3:0] st1;

    obs_t obs0, obs1;
    assign obs0 = {st0, pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rdst0, rw0, asa0,
                   asb0, aop0, pcs0, done0, ill0};
    assign obs1 = {st1, pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rdst1, rw1, asa1,
                   asb1, aop1, pcs1, done1, ill1};

    int n_checks = 0;
    int n_errors = 0;
    obs_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.OP_WIDTH(6), .MEM_WAIT_EN(1'b1), .STATE_WIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .op(op0), .mem_ready(rdy0),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .i_or_d(iord0), .mem_read(mr0),
        .mem_write(mw0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rdst0),
        .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
        .pc_source(pcs0), .instr_done(done0), .illegal_op(ill0), .state_o(st0));

    multicycle_control #(.OP_WIDTH(6), .MEM_WAIT_EN(1'b0), .STATE_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .op(op1), .mem_ready(rdy1),
        .pc_write(pcw1), .pc_write_cond(pcwc1), .i_or_d(iord1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
        .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
        .pc_source(pcs1), .instr_done(done1), .illegal_op(ill1), .state_o(st1));

    // Expected outputs per state, taken from the control table.
    function automatic obs_t model(input logic [3:0] st, input logic rdy, input logic [5:0] opv);
        obs_t m;
        m = '0;
        m.st = st;
        case (st)
            4'd0:  begin m.mr = 1'b1; m.asb = 2'b01; m.irw = rdy; m.pcw = rdy; end
            4'd1:  begin
                m.asb = 2'b11;
                m.ill = !(opv inside {6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b000010, 6'b001000});
            end
            4'd2:  begin m.asa = 1'b1; m.asb = 2'b10; end
            4'd3:  begin m.mr = 1'b1; m.iord = 1'b1; end
            4'd4:  begin m.rw = 1'b1; m.m2r = 1'b1; m.done = 1'b1; end
            4'd5:  begin m.mw = 1'b1; m.iord = 1'b1; m.done = rdy; end
            4'd6:  begin m.asa = 1'b1; m.aop = 2'b10; end
            4'd7:  begin m.rw = 1'b1; m.rdst = 1'b1; m.done = 1'b1; end
            4'd8:  begin m.asa = 1'b1; m.aop = 2'b01; m.pcwc = 1'b1; m.pcs = 2'b01; m.done = 1'b1; end
            4'd9:  begin m.pcw = 1'b1; m.pcs = 2'b10; m.done = 1'b1; end
            4'd10: begin m.asa = 1'b1; m.asb = 2'b10; end
            4'd11: begin m.rw = 1'b1; m.done = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Called at posedge+1: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input int which, input logic [5:0] opv, input logic rdy,
                        input logic [3:0] st, input string tag);
        obs_t got, e;
        string t;
        if (which == 0) begin op0 = opv; rdy0 = rdy; end
        else            begin op1 = opv; rdy1 = rdy; end
        exp_q.push_back(model(st, (which == 1) ? 1'b1 : rdy, opv));
        tag_q.push_back(tag);
        @(negedge clk);
        got = (which == 0) ? obs0 : obs1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (got === e) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", t, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        assert (obs0 === '0 && obs1 === '0) else begin
            n_errors++;
            $error("FAIL %s observed=%h/%h expected=0", tag, obs0, obs1);
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    initial begin
        op0 = LW;
        rdy0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;

        // LW aborted by reset in MEM_ADDR
        step(0, LW, 1'b1, 4'd0, "abort_fetch");
        step(0, LW, 1'b1, 4'd1, "abort_decode");
        #2 reset = 1'b1;
        #1 check_zero("reset_mid_memaddr");
        n_checks++;
        assert (st0 === 4'd0) else begin
            n_errors++;
            $error("FAIL reset_state_o observed=%0d expected=0", st0);
        end
        @(posedge clk);
        #1 check_zero("reset_held");
        reset = 1'b0;
        step(0, LW, 1'b0, 4'd0, "post_reset_fetch");

        // LW, no waits: 0,1,2,3,4
        step(0, LW, 1'b1, 4'd0, "lw_fetch");
        step(0, LW, 1'b1, 4'd1, "lw_decode");
        step(0, LW, 1'b1, 4'd2, "lw_memaddr");
        step(0, LW, 1'b1, 4'd3, "lw_memread");
        step(0, LW, 1'b1, 4'd4, "lw_memwb");

        // SW with two FETCH waits and one MEM_WRITE wait: 7 cycles
        step(0, SW, 1'b0, 4'd0, "sw_fetch_wait1");
        step(0, SW, 1'b0, 4'd0, "sw_fetch_wait2");
        step(0, SW, 1'b1, 4'd0, "sw_fetch_ready");
        step(0, SW, 1'b1, 4'd1, "sw_decode");
        step(0, SW, 1'b1, 4'd2, "sw_memaddr");
        step(0, SW, 1'b0, 4'd5, "sw_memwrite_wait");
        step(0, SW, 1'b1, 4'd5, "sw_memwrite_ready");

        // R-type then BEQ back to back
        step(0, RT, 1'b1, 4'd0, "rt_fetch");
        step(0, RT, 1'b1, 4'd1, "rt_decode");
        step(0, RT, 1'b1, 4'd6, "rt_execute");
        step(0, RT, 1'b1, 4'd7, "rt_done");
        step(0, BEQ, 1'b1, 4'd0, "beq_fetch");
        step(0, BEQ, 1'b1, 4'd1, "beq_decode");
        step(0, BEQ, 1'b1, 4'd8, "beq_branch");

        // unsupported opcode
        step(0, BAD, 1'b1, 4'd0, "ill_fetch");
        step(0, BAD, 1'b1, 4'd1, "ill_decode");
        step(0, BAD, 1'b0, 4'd0, "ill_back_to_fetch");

        // wait handshake disabled: mem_ready held low on dut1
        reset = 1'b1;
        @(posedge clk);
        #1 check_zero("reset_again");
        reset = 1'b0;
        step(1, JMP, 1'b0, 4'd0, "nw_j_fetch");
        step(1, JMP, 1'b0, 4'd1, "nw_j_decode");
        step(1, JMP, 1'b0, 4'd9, "nw_j_jump");
        step(1, ADDI, 1'b0, 4'd0, "nw_addi_fetch");
        step(1, ADDI, 1'b0, 4'd1, "nw_addi_decode");
        step(1, ADDI, 1'b0, 4'd10, "nw_addi_exec");
        step(1, ADDI, 1'b0, 4'd11, "nw_addi_wb");
        step(1, ADDI, 1'b0, 4'd0, "nw_next_fetch");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
